// File: rtl/sram_arb2.sv
// sram_arb2: two-client arbiter in front of a single SRAM controller port.
// A two-state FSM grants one command at a time. Owners of accepted reads are
// recorded in a small tag FIFO so that returning read data, which arrives in
// order, can be strobed to the right client.
module sram_arb2 #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_l,
  // client 0
  input  logic                  c0_req,
  output logic                  c0_ack,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic                  c0_rh_wl,
  input  logic [DATA_WIDTH-1:0] c0_data_w,
  output logic [DATA_WIDTH-1:0] c0_data_r,
  output logic                  c0_data_r_en,
  // client 1
  input  logic                  c1_req,
  output logic                  c1_ack,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic                  c1_rh_wl,
  input  logic [DATA_WIDTH-1:0] c1_data_w,
  output logic [DATA_WIDTH-1:0] c1_data_r,
  output logic                  c1_data_r_en,
  // master side
  output logic                  m_req,
  input  logic                  m_ack,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_rh_wl,
  output logic [DATA_WIDTH-1:0] m_data_w,
  input  logic [DATA_WIDTH-1:0] m_data_r,
  input  logic                  m_data_r_en,
  // status
  output logic                  err_orphan
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(TAG_DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_reg;
  logic             owner_reg;
  logic             prio_reg;
  logic             err_orphan_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             tag_mem [TAG_DEPTH];

  // Client ports gathered into arrays so per-client logic is written once.
  logic [1:0]            req;
  logic [1:0]            rh_wl;
  logic [1:0]            eligible;
  logic [1:0]            ack;
  logic [1:0]            data_r_en;
  logic [ADDR_WIDTH-1:0] addr   [2];
  logic [DATA_WIDTH-1:0] data_w [2];

  logic in_grant;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic orphan;
  logic grant_sel;
  logic head_tag;

  assign req       = {c1_req, c0_req};
  assign rh_wl     = {c1_rh_wl, c0_rh_wl};
  assign addr[0]   = c0_addr;
  assign addr[1]   = c1_addr;
  assign data_w[0] = c0_data_w;
  assign data_w[1] = c1_data_w;

  assign in_grant   = (state_reg == GRANT);
  assign fifo_full  = (count_reg == FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  assign head_tag   = tag_mem[rd_ptr_reg];

  // A read is tagged when the controller accepts it; returning data pops the
  // oldest tag. Data with no tag outstanding is an orphan and is dropped.
  assign push   = in_grant & m_ack & m_rh_wl;
  assign pop    = m_data_r_en & ~fifo_empty;
  assign orphan = m_data_r_en & fifo_empty;

  // Reads stall while every tag slot is in use; writes never do, so a write
  // wins over a blocked read even when the reader holds priority.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_client
      assign eligible[gi]  = req[gi] & (~rh_wl[gi] | ~fifo_full);
      assign ack[gi]       = in_grant & m_ack & (owner_reg == 1'(gi));
      assign data_r_en[gi] = pop & (head_tag == 1'(gi));
    end
  endgenerate

  // Tie goes to prio; otherwise whichever client is eligible.
  assign grant_sel = (&eligible) ? prio_reg : eligible[1];

  assign c0_ack       = ack[0];
  assign c1_ack       = ack[1];
  assign c0_data_r_en = data_r_en[0];
  assign c1_data_r_en = data_r_en[1];

  // Read data is broadcast to both clients; only the strobes are routed.
  // Held at zero while reset is asserted so every output is quiet then.
  assign c0_data_r = reset_l ? m_data_r : '0;
  assign c1_data_r = reset_l ? m_data_r : '0;

  // Master command is the owner's command during GRANT and all-zero in IDLE.
  assign m_req    = in_grant;
  assign m_addr   = in_grant ? addr[owner_reg]   : '0;
  assign m_rh_wl  = in_grant ? rh_wl[owner_reg]  : 1'b0;
  assign m_data_w = in_grant ? data_w[owner_reg] : '0;

  assign err_orphan = err_orphan_reg;

  // Arbitration FSM: grant on an eligible request, release on m_ack.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      prio_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|eligible) begin
            owner_reg <= grant_sel;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          if (m_ack) begin
            prio_reg  <= ~owner_reg;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Tag FIFO pointers, occupancy and the sticky orphan flag. An orphan return
  // never pops, so a read accepted in the same cycle still gets its tag.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      err_orphan_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + ONE_CNT;
        2'b01:   count_reg <= count_reg - ONE_CNT;
        default: count_reg <= count_reg;
      endcase
      if (orphan) err_orphan_reg <= 1'b1;
    end
  end

  // Tag storage; contents are only meaningful between the pointers, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_reg] <= owner_reg;
  end

endmodule

// File: tb/tb_sram_arb2.sv
// tb_sram_arb2: directed bench for sram_arb2. A queue-based model of the
// arbiter is checked against the DUT on every falling edge; directed steps
// add hand-computed literal expectations on top of the model.
module tb_sram_arb2;

  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_l = 1'b0;
  logic          c0_req = 1'b0, c1_req = 1'b0;
  logic          c0_ack, c1_ack;
  logic [AW-1:0] c0_addr = '0, c1_addr = '0;
  logic          c0_rh_wl = 1'b0, c1_rh_wl = 1'b0;
  logic [DW-1:0] c0_data_w = '0, c1_data_w = '0;
  logic [DW-1:0] c0_data_r, c1_data_r;
  logic          c0_data_r_en, c1_data_r_en;
  logic          m_req;
  logic          m_ack = 1'b0;
  logic [AW-1:0] m_addr;
  logic          m_rh_wl;
  logic [DW-1:0] m_data_w;
  logic [DW-1:0] m_data_r = '0;
  logic          m_data_r_en = 1'b0;
  logic          err_orphan;

  always #5 clk = ~clk;

  sram_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_l(reset_l),
    .c0_req(c0_req), .c0_ack(c0_ack), .c0_addr(c0_addr), .c0_rh_wl(c0_rh_wl),
    .c0_data_w(c0_data_w), .c0_data_r(c0_data_r), .c0_data_r_en(c0_data_r_en),
    .c1_req(c1_req), .c1_ack(c1_ack), .c1_addr(c1_addr), .c1_rh_wl(c1_rh_wl),
    .c1_data_w(c1_data_w), .c1_data_r(c1_data_r), .c1_data_r_en(c1_data_r_en),
    .m_req(m_req), .m_ack(m_ack), .m_addr(m_addr), .m_rh_wl(m_rh_wl),
    .m_data_w(m_data_w), .m_data_r(m_data_r), .m_data_r_en(m_data_r_en),
    .err_orphan(err_orphan)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Literal expectation handed from the stimulus thread to the checker.
  typedef enum int {L_NONE, L_MREQ, L_MADDR, L_MDW, L_ACK0, L_ACK1,
                    L_EN0, L_EN1, L_ERR} lit_t;
  lit_t        lit_id   = L_NONE;
  logic [31:0] lit_val  = '0;
  string       lit_name = "";
  int          lit_seq  = 0;
  int          lit_seen = 0;

  // Model state: is a command in flight, whose, who wins a tie, read owners.
  bit busy = 1'b0;
  bit own  = 1'b0;
  bit prio = 1'b0;
  bit err  = 1'b0;
  bit tags [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Compare process: check outputs against the model, then advance the model.
  always @(negedge clk) begin
    logic          e_ack0, e_ack1, e_en0, e_en1, strobe, el0, el1, full;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_dw, e_dr;
    logic          e_rw;
    logic [31:0]   lit_act;

    if (!reset_l) begin
      busy = 1'b0; own = 1'b0; prio = 1'b0; err = 1'b0;
      tags.delete();
    end

    e_addr = busy ? (own ? c1_addr   : c0_addr)   : '0;
    e_dw   = busy ? (own ? c1_data_w : c0_data_w) : '0;
    e_rw   = busy ? (own ? c1_rh_wl  : c0_rh_wl)  : 1'b0;
    e_ack0 = busy && m_ack && !own;
    e_ack1 = busy && m_ack && own;
    strobe = m_data_r_en && (tags.size() > 0);
    e_en0  = strobe && (tags[0] == 1'b0);
    e_en1  = strobe && (tags[0] == 1'b1);
    e_dr   = reset_l ? m_data_r : '0;

    chk("m_req",        32'(m_req),        32'(busy));
    chk("m_addr",       32'(m_addr),       32'(e_addr));
    chk("m_rh_wl",      32'(m_rh_wl),      32'(e_rw));
    chk("m_data_w",     32'(m_data_w),     32'(e_dw));
    chk("c0_ack",       32'(c0_ack),       32'(e_ack0));
    chk("c1_ack",       32'(c1_ack),       32'(e_ack1));
    chk("c0_data_r_en", 32'(c0_data_r_en), 32'(e_en0));
    chk("c1_data_r_en", 32'(c1_data_r_en), 32'(e_en1));
    chk("c0_data_r",    32'(c0_data_r),    32'(e_dr));
    chk("c1_data_r",    32'(c1_data_r),    32'(e_dr));
    chk("err_orphan",   32'(err_orphan),   32'(err));

    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      case (lit_id)
        L_MREQ:  lit_act = 32'(m_req);
        L_MADDR: lit_act = 32'(m_addr);
        L_MDW:   lit_act = 32'(m_data_w);
        L_ACK0:  lit_act = 32'(c0_ack);
        L_ACK1:  lit_act = 32'(c1_ack);
        L_EN0:   lit_act = 32'(c0_data_r_en);
        L_EN1:   lit_act = 32'(c1_data_r_en);
        L_ERR:   lit_act = 32'(err_orphan);
        default: lit_act = 32'hDEAD_BEEF;
      endcase
      chk(lit_name, lit_act, lit_val);
    end

    if (reset_l) begin
      full = (tags.size() >= DEPTH);
      el0  = c0_req && (!c0_rh_wl || !full);
      el1  = c1_req && (!c1_rh_wl || !full);
      if (m_data_r_en) begin
        if (tags.size() > 0) tags.delete(0);
        else err = 1'b1;
      end
      if (busy) begin
        if (m_ack) begin
          if (own ? c1_rh_wl : c0_rh_wl) tags.push_back(own);
          prio = !own;
          busy = 1'b0;
        end
      end else if (el0 || el1) begin
        own  = (el0 && el1) ? prio : el1;
        busy = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input lit_t id, input logic [31:0] val, input string name);
    lit_id   = id;
    lit_val  = val;
    lit_name = name;
    lit_seq++;
  endtask

  // One read by a single client: grant, ack, release.
  task automatic do_read(input bit cl, input logic [AW-1:0] a);
    if (cl) begin c1_req = 1'b1; c1_rh_wl = 1'b1; c1_addr = a; end
    else    begin c0_req = 1'b1; c0_rh_wl = 1'b1; c0_addr = a; end
    step();
    m_ack = 1'b1;
    step();
    m_ack = 1'b0; c0_req = 1'b0; c1_req = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    lit(L_MREQ, 0, "reset_mreq");
    step();
    lit(L_ERR, 0, "reset_err");

    // Single write, ack two cycles after m_req; request present at release
    reset_l = 1'b1;
    c0_req = 1'b1; c0_rh_wl = 1'b0; c0_addr = 'h00010; c0_data_w = 8'hA5;
    step();
    lit(L_MADDR, 'h10, "wr_addr");
    step();
    lit(L_MDW, 'hA5, "wr_data");
    step();
    m_ack = 1'b1;
    lit(L_ACK0, 1, "wr_ack0");
    step();
    m_ack = 1'b0; c0_req = 1'b0;
    lit(L_MREQ, 0, "wr_idle");
    step();

    // Contention from reset: c0, c1, c0, c1 with one idle cycle between
    reset_l = 1'b0;
    step();
    reset_l = 1'b1;
    c0_req = 1'b1; c0_rh_wl = 1'b0; c0_addr = 'h00100; c0_data_w = 8'h01;
    c1_req = 1'b1; c1_rh_wl = 1'b0; c1_addr = 'h00200; c1_data_w = 8'h02;
    m_ack = 1'b1;
    step(); lit(L_MADDR, 'h100, "cont_g0_c0");
    step(); lit(L_MREQ, 0, "cont_gap0");
    step(); lit(L_MADDR, 'h200, "cont_g1_c1");
    step(); lit(L_MREQ, 0, "cont_gap1");
    step(); lit(L_MADDR, 'h100, "cont_g2_c0");
    step(); lit(L_MREQ, 0, "cont_gap2");
    step(); lit(L_ACK1, 1, "cont_g3_c1");
    step();
    c0_req = 1'b0; c1_req = 1'b0; m_ack = 1'b0;
    step();

    // Read routing: c1 read then c0 read, data returns in order
    c1_req = 1'b1; c1_rh_wl = 1'b1; c1_addr = 'h00300;
    step();
    m_ack = 1'b1;
    lit(L_ACK1, 1, "rd_ack1");
    step();
    c1_req = 1'b0; m_ack = 1'b0;
    c0_req = 1'b1; c0_rh_wl = 1'b1; c0_addr = 'h00400;
    step();
    m_ack = 1'b1;
    step();
    c0_req = 1'b0; m_ack = 1'b0;
    m_data_r = 8'h11; m_data_r_en = 1'b1;
    lit(L_EN1, 1, "rd_route_c1");
    step();
    m_data_r = 8'h22;
    lit(L_EN0, 1, "rd_route_c0");
    step();
    m_data_r_en = 1'b0;
    step();

    // Fill the tag FIFO: c0, c0, c0, c1 (leaves prio with c0)
    do_read(1'b0, 'h00010);
    do_read(1'b0, 'h00011);
    do_read(1'b0, 'h00012);
    do_read(1'b1, 'h00013);
    // Blocked c0 read versus c1 write: the write goes first
    c0_req = 1'b1; c0_rh_wl = 1'b1; c0_addr = 'h00500;
    c1_req = 1'b1; c1_rh_wl = 1'b0; c1_addr = 'h00600; c1_data_w = 8'h5A;
    step();
    lit(L_MADDR, 'h600, "full_write_wins");
    step();
    m_ack = 1'b1;
    lit(L_MDW, 'h5A, "full_write_data");
    step();
    c1_req = 1'b0; m_ack = 1'b0;
    lit(L_MREQ, 0, "full_stall0");
    step();
    lit(L_MREQ, 0, "full_stall1");
    m_data_r = 8'h33; m_data_r_en = 1'b1;
    step();
    m_data_r_en = 1'b0;
    lit(L_MREQ, 0, "full_stall2");
    step();
    lit(L_MADDR, 'h500, "full_regrant");
    // accept a read while data returns: count stays put
    m_ack = 1'b1; m_data_r = 8'h44; m_data_r_en = 1'b1;
    step();
    m_ack = 1'b0; m_data_r_en = 1'b0; c0_addr = 'h00501;
    lit(L_MREQ, 0, "gap_after_ack");
    step();
    m_ack = 1'b1;
    lit(L_MADDR, 'h501, "last_slot_read");
    step();
    m_ack = 1'b0; c0_addr = 'h00502;
    step();
    lit(L_MREQ, 0, "full_block0");
    step();
    lit(L_MREQ, 0, "full_block1");
    c0_req = 1'b0;
    // Drain: tags are c0, c1, c0, c0
    m_data_r_en = 1'b1; m_data_r = 8'h61;
    lit(L_EN0, 1, "drain0_c0");
    step();
    m_data_r = 8'h62; lit(L_EN1, 1, "drain1_c1");
    step();
    m_data_r = 8'h63; lit(L_EN0, 1, "drain2_c0");
    step();
    m_data_r = 8'h64; lit(L_EN0, 1, "drain3_c0");
    step();
    // Orphan return
    m_data_r = 8'h70; lit(L_EN0, 0, "orphan_no_strobe");
    step();
    m_data_r_en = 1'b0;
    lit(L_ERR, 1, "orphan_err");
    step(); step();
    lit(L_ERR, 1, "orphan_sticky");
    step();

    // Reset mid-grant with one read tag outstanding
    c1_req = 1'b1; c1_rh_wl = 1'b1; c1_addr = 'h00700;
    step();
    m_ack = 1'b1;
    step();
    m_ack = 1'b0; c1_addr = 'h00701;
    step();
    lit(L_MREQ, 1, "pre_reset_grant");
    step();
    reset_l = 1'b0; m_ack = 1'b1;
    lit(L_MREQ, 0, "reset_drops_mreq");
    step();
    lit(L_ACK1, 0, "reset_no_ack");
    step();
    reset_l = 1'b1; c1_req = 1'b0; m_ack = 1'b0;
    lit(L_ERR, 0, "reset_clears_err");
    step();
    m_data_r = 8'h7E; m_data_r_en = 1'b1;
    lit(L_EN1, 0, "lost_tag_orphan");
    step();
    m_data_r_en = 1'b0;
    lit(L_ERR, 1, "lost_tag_err");
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
